// File: rtl/pixel_feeder_if.sv
// Signal bundle between pixel_feeder, its job controller, the pixel RAM and the convolver.
interface pixel_feeder_if #(
  parameter int dataWidth = 16,
  parameter int addrWidth = 16
);
  logic                 start;
  logic [7:0]           num_ch;
  logic [addrWidth-1:0] base_addr;
  logic                 stall;
  logic                 mem_rd_en;
  logic [addrWidth-1:0] mem_addr;
  logic [dataWidth-1:0] mem_data;
  logic [dataWidth-1:0] pixel_out;
  logic                 ce_out;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, num_ch, base_addr, stall, mem_data,
    output mem_rd_en, mem_addr, pixel_out, ce_out, busy, done
  );

  modport slave (
    output start, num_ch, base_addr, stall, mem_data,
    input  mem_rd_en, mem_addr, pixel_out, ce_out, busy, done
  );
endinterface

// File: rtl/pixel_feeder.sv
// Streams num_ch square WxW frames from RAM in raster order into a registered
// pixel/clock-enable pair, with a stall that freezes the whole read pipeline.
module pixel_feeder #(
  parameter int dataWidth = 16,
  parameter int W         = 28,
  parameter int addrWidth = 16
) (
  input  logic           clk,
  input  logic           global_rst,
  pixel_feeder_if.master bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        col, row;
  logic [7:0]           ch, nch_m1;
  logic [addrWidth-1:0] addr;
  logic                 v1, ce_q;
  logic [dataWidth-1:0] pix;
  logic                 rd, last_rd, accept, exit_ok;

  assign last_rd = (col == CW'(W - 1)) && (row == CW'(W - 1)) && (ch == nch_m1);

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    accept    = 1'b0;
    exit_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        rd = ~bus.stall;
        if (rd && last_rd) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The completion cycle already counts as idle, so a start here is taken.
        if (!v1 && !ce_q) begin
          exit_ok = 1'b1;
          if (bus.start) begin
            accept    = 1'b1;
            state_nxt = STREAM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      state  <= IDLE;
      col    <= '0;
      row    <= '0;
      ch     <= '0;
      nch_m1 <= '0;
      addr   <= '0;
      v1     <= 1'b0;
      ce_q   <= 1'b0;
      pix    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr   <= bus.base_addr;
        col    <= '0;
        row    <= '0;
        ch     <= '0;
        nch_m1 <= (bus.num_ch == 8'd0) ? 8'd0 : bus.num_ch - 8'd1;
      end else if (rd && !last_rd) begin
        // Frames are contiguous, so base + ch*W*W + row*W + col is a plain increment.
        addr <= addr + addrWidth'(1);
        if (col == CW'(W - 1)) begin
          col <= '0;
          if (row == CW'(W - 1)) begin
            row <= '0;
            ch  <= ch + 8'd1;
          end else begin
            row <= row + CW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end
      if (!bus.stall) begin
        v1   <= rd;
        pix  <= bus.mem_data;
        ce_q <= v1;
      end else begin
        ce_q <= 1'b0;
      end
    end
  end

  assign bus.mem_rd_en = rd;
  assign bus.mem_addr  = addr;
  assign bus.pixel_out = pix;
  assign bus.ce_out    = ce_q;
  assign bus.done      = exit_ok;
  assign bus.busy      = (state != IDLE) && !exit_ok;
endmodule
